// File: rtl/shift_seq_ctrl.sv
// Command sequencer for the 8-bit left/right shift register: shifts a command word in over sl/sr/sdin
// and keeps a shadow of the register. Optional q-vs-shadow checker enabled by SHIFT_SEQ_CHECK_EN.
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             sl,
  output logic             sr,
  output logic             sdin,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] shadow,
  input  logic [WIDTH-1:0] q
`ifdef SHIFT_SEQ_CHECK_EN
  ,
  output logic             mismatch
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

  state_t           state_r, state_s;
  logic             dir_r, dir_s;
  logic [WIDTH-1:0] data_r, data_s;
  logic [CNT_W-1:0] n_r, n_s;
  logic [CNT_W-1:0] k_r, k_s;
  logic             sl_r, sl_s;
  logic             sr_r, sr_s;
  logic             sdin_r, sdin_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             aborted_r, aborted_s;
  logic             ready_r, ready_s;
  logic [WIDTH-1:0] shadow_r, shadow_s;

  // A count of zero or beyond the register width means a full-width load.
  function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] cnt);
    if ((cnt == ZERO_C) || (cnt > WIDTH_C)) begin
      return WIDTH_C;
    end else begin
      return cnt;
    end
  endfunction

  function automatic logic pick_bit(input logic [WIDTH-1:0] data, input logic dir,
                                    input logic [CNT_W-1:0] n, input logic [CNT_W-1:0] k);
    logic [CNT_W-1:0] idx;
    logic [WIDTH-1:0] tmp;
    idx = dir ? k : (n - k - ONE_C);
    tmp = data >> idx;
    return tmp[0];
  endfunction

  // Next-state, next-output and shadow-register logic.
  always_comb begin
    state_s   = state_r;
    dir_s     = dir_r;
    data_s    = data_r;
    n_s       = n_r;
    k_s       = k_r;
    sl_s      = 1'b0;
    sr_s      = 1'b0;
    sdin_s    = 1'b0;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    aborted_s = 1'b0;
    ready_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && ready_r) begin
          state_s = ST_SHIFT;
          dir_s   = cmd_dir;
          data_s  = cmd_data;
          n_s     = eff_count(cmd_count);
          k_s     = ZERO_C;
          busy_s  = 1'b1;
          sl_s    = ~cmd_dir;
          sr_s    = cmd_dir;
          sdin_s  = pick_bit(cmd_data, cmd_dir, eff_count(cmd_count), ZERO_C);
        end else begin
          ready_s = 1'b1;
        end
      end
      ST_SHIFT: begin
        // The shift in flight at this edge still lands; abort only stops later ones.
        if (abort || (k_r == (n_r - ONE_C))) begin
          state_s   = ST_DONE;
          done_s    = 1'b1;
          aborted_s = abort;
        end else begin
          k_s    = k_r + ONE_C;
          busy_s = 1'b1;
          sl_s   = ~dir_r;
          sr_s   = dir_r;
          sdin_s = pick_bit(data_r, dir_r, n_r, k_r + ONE_C);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        ready_s = 1'b1;
      end
      default: begin
        state_s = ST_IDLE;
        ready_s = 1'b1;
      end
    endcase

    if (sl_r) begin
      shadow_s = {shadow_r[WIDTH-2:0], sdin_r};
    end else if (sr_r) begin
      shadow_s = {sdin_r, shadow_r[WIDTH-1:1]};
    end else begin
      shadow_s = shadow_r;
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      dir_r     <= 1'b0;
      data_r    <= {WIDTH{1'b0}};
      n_r       <= ZERO_C;
      k_r       <= ZERO_C;
      sl_r      <= 1'b0;
      sr_r      <= 1'b0;
      sdin_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      ready_r   <= 1'b1;
      shadow_r  <= {WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      dir_r     <= dir_s;
      data_r    <= data_s;
      n_r       <= n_s;
      k_r       <= k_s;
      sl_r      <= sl_s;
      sr_r      <= sr_s;
      sdin_r    <= sdin_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      aborted_r <= aborted_s;
      ready_r   <= ready_s;
      shadow_r  <= shadow_s;
    end
  end

  assign cmd_ready = ready_r;
  assign sl        = sl_r;
  assign sr        = sr_r;
  assign sdin      = sdin_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign aborted   = aborted_r;
  assign shadow    = shadow_r;

`ifdef SHIFT_SEQ_CHECK_EN
  logic shifted_r;
  logic mismatch_r;

  // Sticky compare of the real register against the shadow in the cycle after each shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shifted_r  <= 1'b0;
      mismatch_r <= 1'b0;
    end else begin
      shifted_r  <= sl_r | sr_r;
      mismatch_r <= mismatch_r | (shifted_r & (q != shadow_r));
    end
  end

  assign mismatch = mismatch_r;
`else
  logic unused_q;
  assign unused_q = ^q;
`endif

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Command sequencer for the team's 8-bit left/right shift register (ports sl, sr, din, clk, reset, q). It accepts a command over a valid/ready handshake and drives sl/sr/din for a programmed number of cycles to shift a data word in. It keeps a shadow copy of the expected register contents and signals completion. It sits between a host/bus interface and the shift register, which it controls exclusively.

Parameters:
WIDTH, 8, shift register width and data word width
CNT_W, 4, width of shift count field; must satisfy 2**CNT_W > WIDTH

Ports:
clk  in  1  rising-edge clock, shared with the shift register
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_dir  in  1  0 = shift left (sl), 1 = shift right (sr)
cmd_data  in  WIDTH  bits to shift in
cmd_count  in  CNT_W  number of shifts; 0 and values > WIDTH are treated as WIDTH
abort  in  1  synchronous abort of the active command
sl  out  1  shift-left enable to the shift register
sr  out  1  shift-right enable to the shift register
sdin  out  1  serial data to the shift register din
busy  out  1  command in progress (SHIFT state)
done  out  1  one-cycle pulse when a command completes or is aborted
aborted  out  1  valid with done; 1 = command ended by abort
shadow  out  WIDTH  expected shift register contents
q  in  WIDTH  shift register output; used only when SHIFT_SEQ_CHECK_EN is defined

Behaviour:
- Reset, asynchronous: state=IDLE; sl=sr=sdin=0; busy=done=aborted=0; shadow=0; cmd_ready=1 once reset is deasserted.
- Shift register model, fixed: on a clk edge with sl=1, q <= {q[WIDTH-2:0], din}. With sr=1, q <= {din, q[WIDTH-1:1]}. The controller never asserts sl and sr together.
- All outputs are registered.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready at edge E0, the controller latches dir, data and effective count N (1..WIDTH), sets k=0 and goes to SHIFT.
- SHIFT: lasts exactly N cycles starting after E0. busy=1 and cmd_ready=0 throughout.
- In cycle k (k=0..N-1), the selected enable (sl if dir=0, sr if dir=1) is 1.
- sdin in cycle k: data[N-1-k] for left shifts, data[k] for right shifts. After N left shifts, the low N bits of q equal data[N-1:0].
- shadow updates on the same edge as the shift register, using the model above.
- After the last shift edge the controller goes to DONE.
- DONE: lasts one cycle. done=1, aborted=0, sl=sr=0. The next state is IDLE.
- Command-to-done latency is N+1 cycles after E0; the next command can be accepted N+2 cycles after E0.
- abort in SHIFT: sampled at an edge. sl/sr deassert at that edge, so no further shifts occur. The controller goes to DONE with aborted=1. shadow keeps the shifts already performed.
- abort in IDLE or DONE is ignored.
- abort and cmd_valid together in IDLE: the command is accepted and the abort is ignored.
- cmd_valid while not ready: the command is ignored. The upstream holds it until cmd_ready=1.
- Reset mid-SHIFT: returns immediately to the reset state. No done pulse. shadow=0, matching the shift register, which shares reset.
- Counter: k is CNT_W bits and compares against N-1. It does not wrap, because N <= WIDTH < 2**CNT_W.

Optional Feature:
Macro SHIFT_SEQ_CHECK_EN.
- Defined: adds output port mismatch (1 bit, sticky). In each cycle after a shift edge, the controller compares q to shadow. Any difference sets mismatch=1, which holds until reset.
- Not defined: the q port exists but is unused, no mismatch port, no compare logic.

Test Plan:
- Reset asserted 12 ns then released -> sl=sr=sdin=0, shadow=8'h00, cmd_ready=1, done=0.
- Left command, data=8'hA5, count=0 (means 8) -> sl=1 for 8 cycles, sdin sequence 1,0,1,0,0,1,0,1; done after 9 cycles; shadow=q=8'hA5; aborted=0.
- Right command, data=8'h0B, count=3, shadow=8'hA5 -> sr=1 for 3 cycles, sdin 1,1,0; shadow=8'h74; done at cycle 4.
- abort asserted on the 3rd edge of a left, count=8, data=8'hFF command from shadow=0 -> exactly 3 shifts occur; shadow=8'h07; done=1 and aborted=1; cmd_ready=1 on the following cycle.
- cmd_valid held high across two back-to-back commands -> the second is accepted exactly N+2 cycles after the first; reset asserted mid-SHIFT -> outputs go to 0 immediately and no done pulse occurs.
- With SHIFT_SEQ_CHECK_EN defined, q forced to differ from shadow by one bit after a shift -> mismatch=1 next cycle and stays 1 until reset.
